// File: rtl/sumram_drain_if.sv
// sumram_drain_if
//   Bundles the two buses of the partial-sum drain engine:
//     - RAM read port : O_raddr (address out), I_rdata (signed sum back)
//     - output stream : O_tdata / O_tvalid / O_tlast (out), I_tready (in)
//   Modports:
//     master : the drain engine (drives address and stream)
//     slave  : the RAM + downstream consumer side
interface sumram_drain_if #(
  parameter int C_DSIZE = 24,
  parameter int C_ASIZE = 10,
  parameter int C_OSIZE = 8
);
  logic [C_ASIZE-1:0] O_raddr;
  logic [C_DSIZE-1:0] I_rdata;
  logic [C_OSIZE-1:0] O_tdata;
  logic               O_tvalid;
  logic               O_tlast;
  logic               I_tready;

  modport master (
    output O_raddr, O_tdata, O_tvalid, O_tlast,
    input  I_rdata, I_tready
  );

  modport slave (
    input  O_raddr, O_tdata, O_tvalid, O_tlast,
    output I_rdata, I_tready
  );
endinterface

// File: rtl/sumram_drain.sv
// sumram_drain
//   Drains I_len accumulated sums from a partial-sum RAM (fixed read latency
//   C_RD_LAT), requantizes each one (round-half-up right shift by I_shift,
//   signed saturation to C_OSIZE bits) and streams the results out through a
//   first-word-fall-through FIFO of depth C_RD_LAT+2 with valid/ready/last.
//   Reads are credit-limited so that in-flight reads plus FIFO contents never
//   exceed the FIFO depth; no sample is lost under any back-pressure.
// Ports:
//   I_clk, I_rst_n  clock, asynchronous active-low reset
//   I_start         one-cycle pulse starting a pass (sampled only in IDLE)
//   I_len, I_shift  pass length (0..2^C_ASIZE) and requant shift
//   O_busy, O_done  pass in progress / one-cycle completion pulse
//   bus (master)    RAM read port and output stream
// Build option:
//   SUMRAM_DRAIN_RELU_EN  when defined, negative requantized values clamp to 0.
module sumram_drain #(
  parameter int C_DSIZE  = 24,
  parameter int C_ASIZE  = 10,
  parameter int C_OSIZE  = 8,
  parameter int C_RD_LAT = 2
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_start,
  input  logic [C_ASIZE:0]   I_len,
  input  logic [4:0]         I_shift,
  output logic               O_busy,
  output logic               O_done,
  sumram_drain_if.master     bus
);

  localparam int DEPTH  = C_RD_LAT + 2;          // total FIFO depth incl. output register
  localparam int SDEPTH = DEPTH - 1;             // storage behind the output register
  localparam int PW     = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int QW     = C_DSIZE + 1;

  localparam logic [CW-1:0]      DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [PW-1:0]      PTR_LAST = PW'(SDEPTH - 1);
  localparam logic [C_ASIZE:0]   LEN_ZERO = {(C_ASIZE+1){1'b0}};
  localparam logic [C_ASIZE:0]   LEN_ONE  = {{C_ASIZE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [C_ASIZE:0]    cnt;        // next address to issue; reaches len without wrapping
  logic [C_ASIZE:0]    len_q;
  logic [4:0]          shift_q;
  logic [C_RD_LAT:0]   vpipe;      // bit k set: a read issued k cycles ago
  logic [C_RD_LAT:0]   lpipe;      // companion "last entry" flag
  logic [CW-1:0]       used;       // reads in flight + FIFO occupancy
  logic [C_OSIZE:0]    mem [SDEPTH];
  logic [PW-1:0]       rp, wp;
  logic [CW-1:0]       scnt;

  logic                issue, issue_last, pop, out_free, wr, wlast, spop, spush;
  logic [C_ASIZE:0]    cnt_next;
  logic [C_OSIZE-1:0]  qdata;

  // Round-half-up shift, optional ReLU clamp, signed saturation; the extra
  // bit of headroom keeps the rounding add from overflowing.
  function automatic logic [C_OSIZE-1:0] requant(input logic [C_DSIZE-1:0] raw,
                                                 input logic [4:0] sh);
    logic signed [QW-1:0] x, rnd, maxv, minv;
    logic [C_OSIZE-1:0]   res;
    x    = {raw[C_DSIZE-1], raw};
    maxv = {{(QW-C_OSIZE+1){1'b0}}, {(C_OSIZE-1){1'b1}}};
    minv = {{(QW-C_OSIZE+1){1'b1}}, {(C_OSIZE-1){1'b0}}};
    if (sh != 5'd0) begin
      rnd = {{(QW-1){1'b0}}, 1'b1} << (sh - 5'd1);
      x   = (x + rnd) >>> sh;
    end else begin
      x = x;
    end
`ifdef SUMRAM_DRAIN_RELU_EN
    if (x < {QW{1'b0}}) begin
      x = {QW{1'b0}};
    end else begin
      x = x;
    end
`endif
    if (x > maxv) begin
      res = maxv[C_OSIZE-1:0];
    end else if (x < minv) begin
      res = minv[C_OSIZE-1:0];
    end else begin
      res = x[C_OSIZE-1:0];
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  // Issue decision, FIFO push/pop steering and requantization of returning data
  always_comb begin
    pop        = bus.O_tvalid && bus.I_tready;
    out_free   = !bus.O_tvalid || pop;
    cnt_next   = cnt + LEN_ONE;
    wr         = vpipe[C_RD_LAT];
    wlast      = lpipe[C_RD_LAT];
    qdata      = requant(bus.I_rdata, shift_q);
    spop       = out_free && (scnt != CNT_ZERO);
    // returning data bypasses storage only when the output register is free and storage empty
    spush      = wr && !(out_free && (scnt == CNT_ZERO));
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state)
      IDLE: begin
        issue      = I_start && (I_len != LEN_ZERO);
        issue_last = (I_len == LEN_ONE);
      end
      READ: begin
        // a beat leaving this cycle frees a credit for the read issued this cycle
        issue      = (cnt != len_q) && ((used < DEPTH_C) || pop);
        issue_last = (cnt_next == len_q);
      end
      default: begin
        issue      = 1'b0;
        issue_last = 1'b0;
      end
    endcase
  end

  // Pass control FSM: address issue, busy/done flags
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= IDLE;
      cnt         <= LEN_ZERO;
      len_q       <= LEN_ZERO;
      shift_q     <= 5'd0;
      bus.O_raddr <= {C_ASIZE{1'b0}};
      O_busy      <= 1'b0;
      O_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_start) begin
            len_q       <= I_len;
            shift_q     <= I_shift;
            O_busy      <= 1'b1;
            bus.O_raddr <= {C_ASIZE{1'b0}};
            cnt         <= LEN_ONE;
            if (I_len == LEN_ZERO) begin
              state  <= DONE;
              O_done <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (cnt == len_q) begin
            state <= FLUSH;
          end else if (issue) begin
            bus.O_raddr <= cnt[C_ASIZE-1:0];
            cnt         <= cnt_next;
            if (cnt_next == len_q) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (pop && bus.O_tlast) begin
            state  <= DONE;
            O_done <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          O_done      <= 1'b0;
          O_busy      <= 1'b0;
          bus.O_raddr <= {C_ASIZE{1'b0}};
        end
        default: begin
          state       <= IDLE;
          O_done      <= 1'b0;
          O_busy      <= 1'b0;
          bus.O_raddr <= {C_ASIZE{1'b0}};
        end
      endcase
    end
  end

  // Read-latency tracking, credit counter and output FIFO head/pointers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vpipe        <= {(C_RD_LAT+1){1'b0}};
      lpipe        <= {(C_RD_LAT+1){1'b0}};
      used         <= CNT_ZERO;
      scnt         <= CNT_ZERO;
      rp           <= {PW{1'b0}};
      wp           <= {PW{1'b0}};
      bus.O_tdata  <= {C_OSIZE{1'b0}};
      bus.O_tvalid <= 1'b0;
      bus.O_tlast  <= 1'b0;
    end else begin
      vpipe <= {vpipe[C_RD_LAT-1:0], issue};
      lpipe <= {lpipe[C_RD_LAT-1:0], issue && issue_last};
      used  <= used + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, pop};
      scnt  <= scnt + {{(CW-1){1'b0}}, spush} - {{(CW-1){1'b0}}, spop};
      if (spop) begin
        rp <= ptr_inc(rp);
      end
      if (spush) begin
        wp <= ptr_inc(wp);
      end
      if (out_free) begin
        if (scnt != CNT_ZERO) begin
          {bus.O_tlast, bus.O_tdata} <= mem[rp];
          bus.O_tvalid               <= 1'b1;
        end else if (wr) begin
          {bus.O_tlast, bus.O_tdata} <= {wlast, qdata};
          bus.O_tvalid               <= 1'b1;
        end else begin
          bus.O_tvalid <= 1'b0;
          bus.O_tlast  <= 1'b0;
        end
      end
    end
  end

  // FIFO storage array (data only, no reset needed)
  always_ff @(posedge I_clk) begin
    if (spush) begin
      mem[wp] <= {wlast, qdata};
    end
  end

endmodule

// File: tb/tb_sumram_drain.sv
// tb_sumram_drain
//   Self-checking bench for sumram_drain: a RAM model with fixed read latency,
//   a behavioural requantization reference and scenario tasks for reset,
//   directed data, rounding/saturation, random traffic, back-pressure,
//   zero-length / ignored start, mid-pass reset and a full-RAM drain.
module tb_sumram_drain;
  localparam int DW  = 24;
  localparam int AW  = 10;
  localparam int OW  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len_in = '0;
  logic [4:0]    shift_in = 5'd0;
  logic          busy, done;

  sumram_drain_if #(.C_DSIZE(DW), .C_ASIZE(AW), .C_OSIZE(OW)) bus();

  sumram_drain #(.C_DSIZE(DW), .C_ASIZE(AW), .C_OSIZE(OW), .C_RD_LAT(LAT)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start), .I_len(len_in),
    .I_shift(shift_in), .O_busy(busy), .O_done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM with LAT cycles from address to data
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= ram[bus.O_raddr];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.I_rdata = rd_pipe[LAT-1];

  int passed = 0;
  int total = 0;

  // results of the most recent pass
  int   got_d[$];
  bit   got_l[$];
  int   first_valid, done_cyc, done_cnt, unstable, last_beat_cyc, extra_valid;
  bit   timed_out;
  logic [AW-1:0] raddr_c1;
  logic busy_c1;

  // reference: round half up, floor division, optional ReLU, saturate
  function automatic int model_q(input logic [DW-1:0] raw, input int sh);
    longint v, d, q, hi, lo;
    v  = longint'($signed(raw));
    hi = (longint'(1) << (OW-1)) - 1;
    lo = -(longint'(1) << (OW-1));
    if (sh > 0) begin
      d = longint'(1) << sh;
      v = v + d / 2;
      q = v / d;
      if ((v % d != 0) && (v < 0)) q = q - 1;
    end else begin
      q = v;
    end
`ifdef SUMRAM_DRAIN_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return int'(q);
  endfunction

  task automatic fill_random(input int n);
    int s;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        ram[i] = DW'($urandom());
      end else begin
        s = int'($urandom_range(0, 8191)) - 4096;
        ram[i] = s[DW-1:0];
      end
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: toggling ready plus a 10-cycle stall
  task automatic run_pass(input int n, input int sh, input int mode, input int restart_cyc);
    bit held, finished;
    logic [OW-1:0] held_d;
    logic held_l;
    got_d.delete(); got_l.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; unstable = 0;
    last_beat_cyc = -1; extra_valid = 0; held = 0; finished = 0;
    held_d = '0; held_l = 1'b0;
    @(negedge clk);
    start = 1'b1; len_in = n[AW:0]; shift_in = sh[4:0]; bus.I_tready = 1'b1;
    for (int cyc = 1; cyc <= n * 12 + 60 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == restart_cyc) begin
        start = 1'b1; len_in = 11'd5; shift_in = 5'd3;
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) begin raddr_c1 = bus.O_raddr; busy_c1 = busy; end
      if (held && (!bus.O_tvalid || bus.O_tdata !== held_d || bus.O_tlast !== held_l)) unstable++;
      case (mode)
        1:       bus.I_tready = 1'($urandom_range(0, 1));
        2:       bus.I_tready = (cyc >= 20 && cyc < 30) ? 1'b0 : ((cyc % 2) == 0);
        default: bus.I_tready = 1'b1;
      endcase
      if (bus.O_tvalid && first_valid < 0) first_valid = cyc;
      if (bus.O_tvalid && bus.I_tready) begin
        got_d.push_back(int'($signed(bus.O_tdata)));
        got_l.push_back(bus.O_tlast);
        last_beat_cyc = cyc;
      end
      held = bus.O_tvalid && !bus.I_tready;
      held_d = bus.O_tdata; held_l = bus.O_tlast;
      if (done) begin done_cnt++; done_cyc = cyc; finished = 1; end
    end
    start = 1'b0;
    timed_out = !finished;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (bus.O_tvalid) extra_valid++;
    end
  endtask

  task automatic test_reset();
    bus.I_tready = 1'b0;
    rst_n = 1'b0;
    #12;
    total++; if (bus.O_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", bus.O_tvalid); else passed++;
    total++; if (bus.O_tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", bus.O_tlast); else passed++;
    total++; if (bus.O_tdata !== '0) $display("FAIL reset_tdata: got %0h want 0", bus.O_tdata); else passed++;
    total++; if (bus.O_raddr !== '0) $display("FAIL reset_raddr: got %0h want 0", bus.O_raddr); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || bus.O_tvalid !== 1'b0) $display("FAIL idle_after_reset: busy %b tvalid %b want 0 0", busy, bus.O_tvalid); else passed++;
  endtask

  task automatic test_directed();
    int d4[4] = '{5, -3, 127, 200};
    int e;
    for (int i = 0; i < 4; i++) ram[i] = d4[i][DW-1:0];
    run_pass(4, 0, 0, 0);
    total++; if (got_d.size() != 4) $display("FAIL dir_count: got %0d want 4", got_d.size()); else passed++;
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      e = model_q(ram[i], 0); total++;
      if (got_d[i] !== e || got_l[i] !== (i == 3)) $display("FAIL dir_beat%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], e, (i == 3)); else passed++;
    end
    total++; if (raddr_c1 !== '0 || busy_c1 !== 1'b1) $display("FAIL dir_cycle1: raddr %0d busy %b want 0 1", raddr_c1, busy_c1); else passed++;
    total++; if (first_valid != LAT + 2) $display("FAIL dir_latency: got %0d want %0d", first_valid, LAT + 2); else passed++;
    total++; if (done_cyc != last_beat_cyc + 1) $display("FAIL dir_done_cycle: got %0d want %0d", done_cyc, last_beat_cyc + 1); else passed++;
    total++; if (done_cnt != 1 || timed_out) $display("FAIL dir_done_pulse: got %0d pulses timeout %b want 1 0", done_cnt, timed_out); else passed++;
  endtask

  task automatic test_rounding();
    int d4[4] = '{24, -24, 23, -4096};
    int e;
    for (int i = 0; i < 4; i++) ram[i] = d4[i][DW-1:0];
    run_pass(4, 4, 0, 0);
    total++; if (got_d.size() != 4) $display("FAIL rnd_count: got %0d want 4", got_d.size()); else passed++;
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      e = model_q(ram[i], 4); total++;
      if (got_d[i] !== e || got_l[i] !== (i == 3)) $display("FAIL rnd_beat%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], e, (i == 3)); else passed++;
    end
  endtask

  task automatic test_random();
    int n, sh, e;
    for (int p = 0; p < 4; p++) begin
      n = $urandom_range(1, 64); sh = $urandom_range(0, DW - 1);
      fill_random(n);
      run_pass(n, sh, 1, 0);
      total++; if (got_d.size() != n || timed_out) $display("FAIL rand%0d_count: got %0d want %0d", p, got_d.size(), n); else passed++;
      for (int i = 0; i < n && i < got_d.size(); i++) begin
        e = model_q(ram[i], sh); total++;
        if (got_d[i] !== e || got_l[i] !== (i == n - 1)) $display("FAIL rand%0d_beat%0d: got %0d/%b want %0d/%b", p, i, got_d[i], got_l[i], e, (i == n - 1)); else passed++;
      end
      total++; if (unstable != 0) $display("FAIL rand%0d_stable: got %0d changes want 0", p, unstable); else passed++;
    end
  endtask

  task automatic test_backpressure();
    int e;
    fill_random(16);
    run_pass(16, 3, 2, 0);
    total++; if (got_d.size() != 16 || timed_out) $display("FAIL bp_count: got %0d want 16", got_d.size()); else passed++;
    for (int i = 0; i < 16 && i < got_d.size(); i++) begin
      e = model_q(ram[i], 3); total++;
      if (got_d[i] !== e || got_l[i] !== (i == 15)) $display("FAIL bp_beat%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], e, (i == 15)); else passed++;
    end
    total++; if (unstable != 0) $display("FAIL bp_stable: got %0d changes want 0", unstable); else passed++;
    total++; if (done_cnt != 1) $display("FAIL bp_done: got %0d pulses want 1", done_cnt); else passed++;
  endtask

  task automatic test_zero_len_and_busy();
    int e;
    run_pass(0, 0, 0, 0);
    total++; if (done_cyc != 1) $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); else passed++;
    total++; if (first_valid != -1 || got_d.size() != 0) $display("FAIL zero_no_valid: first %0d beats %0d want -1 0", first_valid, got_d.size()); else passed++;
    total++; if (done_cnt != 1) $display("FAIL zero_done_pulse: got %0d want 1", done_cnt); else passed++;
    fill_random(8);
    run_pass(8, 2, 0, 3);
    total++; if (got_d.size() != 8) $display("FAIL busy_count: got %0d want 8", got_d.size()); else passed++;
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      e = model_q(ram[i], 2); total++;
      if (got_d[i] !== e || got_l[i] !== (i == 7)) $display("FAIL busy_beat%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], e, (i == 7)); else passed++;
    end
    total++; if (done_cnt != 1 || extra_valid != 0 || busy !== 1'b0) $display("FAIL busy_ignored: done %0d extra %0d busy %b want 1 0 0", done_cnt, extra_valid, busy); else passed++;
  endtask

  task automatic test_reset_mid_pass();
    int beats, e, dseen, vseen;
    beats = 0; dseen = 0; vseen = 0;
    fill_random(16);
    @(negedge clk);
    start = 1'b1; len_in = 11'd16; shift_in = 5'd1; bus.I_tready = 1'b1;
    for (int cyc = 1; cyc < 100 && beats < 7; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.O_tvalid && bus.I_tready) beats++;
    end
    total++; if (beats != 7 || bus.O_tvalid !== 1'b1) $display("FAIL mid_reach: beats %0d tvalid %b want 7 1", beats, bus.O_tvalid); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (bus.O_tvalid !== 1'b0 || bus.O_tlast !== 1'b0) $display("FAIL mid_valid_last: got %b %b want 0 0", bus.O_tvalid, bus.O_tlast); else passed++;
    total++; if (bus.O_tdata !== '0 || bus.O_raddr !== '0) $display("FAIL mid_data_addr: got %0h %0h want 0 0", bus.O_tdata, bus.O_raddr); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_busy_done: got %b %b want 0 0", busy, done); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) dseen++;
      if (bus.O_tvalid) vseen++;
    end
    total++; if (dseen != 0 || vseen != 0) $display("FAIL mid_aborted: done %0d valid %0d want 0 0", dseen, vseen); else passed++;
    fill_random(16);
    run_pass(16, 5, 1, 0);
    total++; if (got_d.size() != 16 || done_cnt != 1) $display("FAIL mid_fresh: beats %0d done %0d want 16 1", got_d.size(), done_cnt); else passed++;
    for (int i = 0; i < 16 && i < got_d.size(); i++) begin
      e = model_q(ram[i], 5); total++;
      if (got_d[i] !== e || got_l[i] !== (i == 15)) $display("FAIL mid_beat%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], e, (i == 15)); else passed++;
    end
  endtask

  task automatic test_full_ram();
    int n, sh, e;
    n = 1 << AW; sh = $urandom_range(0, 12);
    fill_random(n);
    run_pass(n, sh, 0, 0);
    total++; if (got_d.size() != n) $display("FAIL full_count: got %0d want %0d", got_d.size(), n); else passed++;
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      e = model_q(ram[i], sh); total++;
      if (got_d[i] !== e || got_l[i] !== (i == n - 1)) $display("FAIL full_beat%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], e, (i == n - 1)); else passed++;
    end
    total++; if (last_beat_cyc != LAT + 2 + n - 1) $display("FAIL full_throughput: last beat %0d want %0d", last_beat_cyc, LAT + 2 + n - 1); else passed++;
    total++; if (done_cnt != 1 || done_cyc != last_beat_cyc + 1) $display("FAIL full_done: pulses %0d cycle %0d want 1 %0d", done_cnt, done_cyc, last_beat_cyc + 1); else passed++;
  endtask

  initial begin
    bus.I_tready = 1'b0;
    test_reset();
    test_directed();
    test_rounding();
    test_random();
    test_backpressure();
    test_zero_len_and_busy();
    test_reset_mid_pass();
    test_full_ram();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sumram_drain.md
SUMRAM_DRAIN -- requirements
Module: sumram_drain

Interface
REQ-001 Parameter C_DSIZE, default 24, accumulator word width read from the partial-sum RAM.
REQ-002 Parameter C_ASIZE, default 10, partial-sum RAM address width.
REQ-003 Parameter C_OSIZE, default 8, output sample width (signed).
REQ-004 Parameter C_RD_LAT, default 2, fixed cycles from O_raddr to valid I_rdata.
REQ-005 I_clk  input  1  sole clock; all logic rising-edge.
REQ-006 I_rst_n  input  1  asynchronous active-low reset.
REQ-007 I_start  input  1  one-cycle pulse; begins a drain pass.
REQ-008 I_len  input  C_ASIZE+1  number of entries to drain, 0..2^C_ASIZE.
REQ-009 I_shift  input  5  requantization right-shift amount, 0..C_DSIZE-1.
REQ-010 O_raddr  output  C_ASIZE  read address to the partial-sum RAM.
REQ-011 I_rdata  input  C_DSIZE  signed accumulated sum, valid C_RD_LAT cycles after O_raddr.
REQ-012 O_tdata  output  C_OSIZE  requantized signed sample.
REQ-013 O_tvalid  output  1  O_tdata valid.
REQ-014 I_tready  input  1  downstream accept; beat transfers when O_tvalid and I_tready.
REQ-015 O_tlast  output  1  marks final beat of the pass.
REQ-016 O_busy  output  1  high from cycle after accepted I_start until O_done.
REQ-017 O_done  output  1  one-cycle pulse at pass completion.

Function
REQ-018 FSM states IDLE, READ, FLUSH, DONE; IDLE->READ on I_start with I_len!=0; IDLE->DONE on I_start with I_len==0.
REQ-019 I_start, I_len, I_shift sampled only in IDLE; I_start in any other state ignored; I_len and I_shift held internally for the pass.
REQ-020 READ issues addresses 0,1,..,I_len-1 in order, one per cycle, only while credit available; READ->FLUSH after last address issued.
REQ-021 Credit: reads in flight plus output FIFO occupancy SHALL never exceed FIFO depth C_RD_LAT+2; no data dropped under any I_tready pattern.
REQ-022 O_raddr holds last issued address when no read issued; 0 in IDLE.
REQ-023 Requant: if I_shift>0, add 2^(I_shift-1) then arithmetic right shift by I_shift; if I_shift==0, pass unchanged; arithmetic at C_DSIZE+1 bits, no internal overflow.
REQ-024 Saturate result to [-2^(C_OSIZE-1), 2^(C_OSIZE-1)-1].
REQ-025 Requantized value registered once, then written to a first-word-fall-through output FIFO.
REQ-026 Latency with I_tready high: I_start sampled at cycle 0 -> O_raddr=0 at cycle 1 -> O_tvalid at cycle C_RD_LAT+2; throughput one beat per cycle thereafter.
REQ-027 O_tdata/O_tlast SHALL hold stable while O_tvalid high and I_tready low.
REQ-028 O_tlast high only on beat I_len-1.
REQ-029 FLUSH->DONE in cycle after the O_tlast beat transfers; DONE lasts one cycle, asserts O_done, returns to IDLE.
REQ-030 I_len==2^C_ASIZE drains full RAM; address counter SHALL not wrap before last issue.

Reset
REQ-031 On I_rst_n low, immediately: FSM=IDLE, FIFO emptied, credit counter 0, O_raddr=0, O_tdata=0, O_tvalid=0, O_tlast=0, O_busy=0, O_done=0.
REQ-032 Reset asserted mid-pass aborts the pass; no O_done, no further beats; next I_start after release begins a fresh pass.

Configuration
REQ-033 Macro SUMRAM_DRAIN_RELU_EN defined: negative requantized values clamp to 0 before saturation (output range 0..2^(C_OSIZE-1)-1).
REQ-034 SUMRAM_DRAIN_RELU_EN undefined: no clamp; signed saturation only; all other behaviour identical.

Verification
REQ-035 I_len=4, I_shift=0, RAM {5,-3,127,200}, I_tready=1 -> beats {5,-3,127,127}, O_tlast on 4th, first O_tvalid cycle 4, O_done one cycle after last beat.
REQ-036 I_shift=4, RAM {24,-24,23,-4096} -> {2,-1,1,-128} (round half up, saturate).
REQ-037 RELU_EN defined, same data as REQ-035 -> {5,0,127,127}.
REQ-038 I_len=16, I_tready toggling 1/0 each cycle plus 10-cycle stall -> 16 beats in order, no loss, no duplicates, data stable during stall.
REQ-039 I_len=0 -> O_done pulse cycle 1, no O_tvalid; I_start during busy ignored.
REQ-040 I_rst_n low at beat 7 of 16 -> all outputs 0 immediately, no O_done; new pass afterward completes normally.
